// File: rtl/demux4_pkg.sv
// Shared definitions for the 4-way dispatch demux: channel count, slot state
// and destination select encodings.
package demux4_pkg;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned SEL_W  = 2;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_t;

   localparam logic [SEL_W-1:0] SEL_CH0 = 2'b00;
   localparam logic [SEL_W-1:0] SEL_CH1 = 2'b01;
   localparam logic [SEL_W-1:0] SEL_CH2 = 2'b10;
   localparam logic [SEL_W-1:0] SEL_CH3 = 2'b11;

endpackage

// File: rtl/demux4_slot.sv
// One-entry channel buffer; a load while FULL replaces the held word.
module demux4_slot
   import demux4_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] q
);

   slot_state_t state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= EMPTY;
         q     <= WIDTH'(0);
      end else begin
         case (state)
            EMPTY: begin
               if (load) begin
                  state <= FULL;
                  q     <= data;
               end
            end
            FULL: begin
               if (load) begin
                  q <= data;
               end else if (ready) begin
                  state <= EMPTY;
               end
            end
         endcase
      end
   end

   assign valid = (state == FULL);

endmodule

// File: rtl/demux4_dispatch.sv
// Routes a valid/ready input stream to one of four one-entry output channels
// selected per word, and counts accepted words.
module demux4_dispatch
   import demux4_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_sel,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [WIDTH-1:0] out_data0,
   output logic [WIDTH-1:0] out_data1,
   output logic [WIDTH-1:0] out_data2,
   output logic [WIDTH-1:0] out_data3,
   output logic             busy,
   output logic [CNT_W-1:0] xfer_cnt
);

   logic [NUM_CH-1:0] slot_ready;
   logic [NUM_CH-1:0] load;
   logic [NUM_CH-1:0] valid_next;
   logic [WIDTH-1:0]  slot_q [NUM_CH];
   logic              fire;

   // A channel can take a word when empty or when it is being drained now.
   assign slot_ready = ~out_valid | out_ready;
   assign in_ready   = slot_ready[in_sel];
   assign fire       = in_valid & in_ready;

   always_comb begin
      load = '0;
      if (fire) begin
         case (in_sel)
            SEL_CH0: load[0] = 1'b1;
            SEL_CH1: load[1] = 1'b1;
            SEL_CH2: load[2] = 1'b1;
            SEL_CH3: load[3] = 1'b1;
         endcase
      end
   end

   assign valid_next = load | (out_valid & ~out_ready);

   for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
      demux4_slot #(.WIDTH(WIDTH)) u_slot (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (load[k]),
         .data  (in_data),
         .ready (out_ready[k]),
         .valid (out_valid[k]),
         .q     (slot_q[k])
      );
   end

   assign out_data0 = slot_q[0];
   assign out_data1 = slot_q[1];
   assign out_data2 = slot_q[2];
   assign out_data3 = slot_q[3];

   // Busy tracks the next-cycle channel occupancy so it lines up with out_valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         xfer_cnt <= CNT_W'(0);
      end else begin
         busy <= |valid_next;
         if (fire) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/demux4_dispatch.md
DEMUX4_DISPATCH -- requirements
Module: demux4_dispatch

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits of every channel.
REQ-002 Parameter CNT_W, default 16, width of the accepted-transfer counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 in_valid  input  1  upstream offers a word.
REQ-006 in_ready  output  1  block accepts the offered word this cycle.
REQ-007 in_data  input  WIDTH  offered word.
REQ-008 in_sel  input  2  destination channel; {s1,s2} encoding: 00->ch0, 01->ch1, 10->ch2, 11->ch3.
REQ-009 out_valid  output  4  bit k set: channel k holds a word.
REQ-010 out_ready  input  4  bit k set: consumer k takes the word this cycle.
REQ-011 out_data0..out_data3  output  WIDTH each  held word of channel k.
REQ-012 busy  output  1  OR of out_valid.
REQ-013 xfer_cnt  output  CNT_W  count of words accepted since reset.

Function
REQ-014 Transfer on input SHALL occur on a cycle where in_valid and in_ready are both 1; the word is routed only to the channel named by in_sel.
REQ-015 Each channel SHALL be a one-entry buffer with two states: EMPTY and FULL.
REQ-016 Transition EMPTY->FULL on input transfer to that channel; FULL->EMPTY on out_valid[k] & out_ready[k] with no input transfer to k; FULL->FULL when drain and input transfer to k coincide (new word replaces the old one).
REQ-017 in_ready SHALL be combinational: 1 when the selected channel is EMPTY, or is FULL with out_ready[k]=1 in the same cycle; 0 otherwise. in_ready SHALL NOT depend on in_valid.
REQ-018 Latency SHALL be one cycle: a word accepted at edge N appears on out_data[k] with out_valid[k]=1 from edge N onward.
REQ-019 out_data[k] SHALL hold stable while out_valid[k]=1 and out_ready[k]=0.
REQ-020 A stalled channel (FULL, out_ready=0) SHALL NOT block input transfers to other channels.
REQ-021 out_data[k] SHALL retain the last word after it is drained; its value is don't-care while out_valid[k]=0.
REQ-022 xfer_cnt SHALL increment by 1 per input transfer and wrap from 2^CNT_W-1 to 0.
REQ-023 in_sel and in_data SHALL be sampled only on a transfer cycle; changes while in_ready=0 SHALL have no effect on state.

Reset
REQ-024 On a clk edge with rst_n=0, every channel SHALL go EMPTY, out_valid=0000, xfer_cnt=0, busy=0; out_data0..3 SHALL reset to 0.
REQ-025 Reset mid-operation SHALL discard held words without a handshake; in_ready SHALL be 1 on the first cycle after rst_n returns high.
REQ-026 While rst_n=0, no transfer SHALL be counted or stored.

Structure
REQ-027 The shared package demux4_pkg SHALL hold NUM_CH=4, the channel state type (EMPTY, FULL), and the in_sel encoding constants.
REQ-028 The one-entry channel buffer SHALL be a sub-module demux4_slot, instantiated four times; the top level holds the select decode, in_ready mux and xfer_cnt.

Verification
REQ-029 Reset then in_sel=10, in_data=A5, in_valid=1, out_ready=1111 -> next cycle out_valid=0100, out_data2=A5, xfer_cnt=1.
REQ-030 out_ready=0000; send 11 to ch0 -> out_valid=0001; offer 22 to ch0 -> in_ready=0, out_data0 stays 11; offer 33 to ch3 -> accepted, out_valid=1001.
REQ-031 ch1 FULL with 44, out_ready[1]=1, same cycle send 55 to ch1 -> in_ready=1, next cycle out_valid[1]=1, out_data1=55, xfer_cnt +1.
REQ-032 Back-to-back sends, in_sel 00,01,10,11 with data 1,2,3,4 and out_ready=1111 -> each appears on its channel one cycle after acceptance, no drops, xfer_cnt=4.
REQ-033 Fill all four channels with out_ready=0000, assert rst_n=0 for one cycle -> out_valid=0000, xfer_cnt=0, busy=0, in_ready=1 after release.
REQ-034 Preload xfer_cnt to FFFF via 65535 transfers (CNT_W=16), one more transfer -> xfer_cnt=0000.
